mem_access_unit: RTL and testbench

Load/store initiator between the CPU execute stage and the word-wide data memory. It turns byte, halfword and word loads and stores into word-aligned memory accesses. Sub-word stores become a read-modify-write (RMW) because the memory only writes whole words. Loads are sign- or zero-extended. Misaligned or out-of-range accesses are flagged as errors and never touch memory.

---
 rtl/cpu_mem_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// lane width and small address helpers.
package cpu_mem_pkg;

    // Width of one byte lane in the memory word.
    localparam int BYTE_W = 8;

    // Access size encodings as they arrive on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        MERGE = 2'b10
    } state_e;

    // A halfword must sit on an even address, a word on a multiple of four.
    function automatic logic isMisaligned(input size_e size, input logic [1:0] addrLo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = addrLo[0];
            SZ_WORD: mis = (addrLo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Memory only sees whole words, so the two lane bits are always cleared.
    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a memory word and right-justified CPU data.
// Extracts and extends the addressed lane for loads, and splices store data
// into the addressed lane of the old word for read-modify-write stores.
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  size_e       size_i,
    input  logic        signed_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [BYTE_W-1:0]   laneByte;
    logic [2*BYTE_W-1:0] laneHalf;

    // Pick the addressed byte and halfword out of the little-endian word.
    always_comb begin
        laneByte = rdata_i[BYTE_W-1:0];
        case (addr_lo_i)
            2'd0: laneByte = rdata_i[7:0];
            2'd1: laneByte = rdata_i[15:8];
            2'd2: laneByte = rdata_i[23:16];
            2'd3: laneByte = rdata_i[31:24];
            default: laneByte = rdata_i[7:0];
        endcase
        laneHalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extend the selected lane to 32 bits; signed_i chooses sign or zero fill.
    always_comb begin
        load_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: load_data_o = {{24{signed_i & laneByte[BYTE_W-1]}}, laneByte};
            SZ_HALF: load_data_o = {{16{signed_i & laneHalf[2*BYTE_W-1]}}, laneHalf};
            default: load_data_o = rdata_i;
        endcase
    end

    // Overwrite only the addressed lane, keeping the neighbouring bytes intact.
    always_comb begin
        merge_data_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                case (addr_lo_i)
                    2'd0: merge_data_o = {rdata_i[31:8], wdata_i[7:0]};
                    2'd1: merge_data_o = {rdata_i[31:16], wdata_i[7:0], rdata_i[7:0]};
                    2'd2: merge_data_o = {rdata_i[31:24], wdata_i[7:0], rdata_i[15:0]};
                    2'd3: merge_data_o = {wdata_i[7:0], rdata_i[23:0]};
                    default: merge_data_o = rdata_i;
                endcase
            end
            SZ_HALF: begin
                merge_data_o = addr_lo_i[1] ? {wdata_i[15:0], rdata_i[15:0]}
                                            : {rdata_i[31:16], wdata_i[15:0]};
            end
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and word-wide data memory.
// Word stores complete in one cycle; loads and sub-word stores take a second
// cycle to see the memory word (sub-word stores write it back merged).
// Illegal accesses are answered with an error and never reach memory.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data,
    output logic        mem_write_en,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data
);

    localparam logic [31:0] SIZE_LIMIT = 32'(SIZE);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    size_e       size_q;
    logic        signed_q;
    logic        respValid_q;
    logic        respErr_q;
    logic [31:0] respRdata_q;

    size_e       reqSize;
    logic        accept;
    logic        reqErr;
    logic        wordStore;
    logic [31:0] alignedAddr;
    logic [31:0] loadData;
    logic [31:0] mergeData;

    // Decode the incoming request and classify it in the accept cycle.
    always_comb begin
        reqSize   = size_e'(req_size);
        req_ready = (state_q == IDLE);
        accept    = req_valid && req_ready;
        reqErr    = (reqSize == SZ_BAD)
                 || isMisaligned(reqSize, req_addr[1:0])
                 || (req_addr >= SIZE_LIMIT);
        wordStore = accept && req_is_store && (reqSize == SZ_WORD) && !reqErr;
    end

    // Memory address comes straight from the request while accepting so the
    // read is already in flight; afterwards it comes from the captured copy.
    always_comb begin
        alignedAddr    = accept ? wordAlign(req_addr) : wordAlign(addr_q);
        mem_read_addr  = alignedAddr;
        mem_write_addr = alignedAddr;
    end

    // Write strobe: immediate for word stores, second cycle for merged stores,
    // and suppressed while reset is held so an abandoned merge never lands.
    always_comb begin
        mem_write_en   = !reset && (wordStore || (state_q == MERGE));
        mem_write_data = (state_q == MERGE) ? mergeData : req_wdata;
    end

    mem_lane_align u_lane_align (
        .addr_lo_i    (addr_q[1:0]),
        .size_i       (size_q),
        .signed_i     (signed_q),
        .rdata_i      (mem_read_data),
        .wdata_i      (wdata_q),
        .load_data_o  (loadData),
        .merge_data_o (mergeData)
    );

    // Control FSM with registered response; responses are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            respValid_q <= 1'b0;
            respErr_q   <= 1'b0;
            respRdata_q <= '0;
        end else begin
            respValid_q <= 1'b0;
            respErr_q   <= 1'b0;
            respRdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        size_q   <= reqSize;
                        signed_q <= req_signed;
                        if (reqErr) begin
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b1;
                        end else if (req_is_store && (reqSize == SZ_WORD)) begin
                            respValid_q <= 1'b1;
                        end else if (!req_is_store) begin
                            state_q <= LOAD;
                        end else begin
                            state_q <= MERGE;
                        end
                    end
                end
                LOAD: begin
                    respValid_q <= 1'b1;
                    respRdata_q <= loadData;
                    state_q     <= IDLE;
                end
                MERGE: begin
                    respValid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = respValid_q;
    assign resp_err   = respErr_q;
    assign resp_rdata = respRdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a word memory model hangs off the memory
// port, a reference copy of memory predicts every response and write, and
// expected events are queued with the cycle they must appear in.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } write_t;

    resp_t  respQ[$];
    write_t writeQ[$];

    logic [31:0] memArr [0:1023];
    logic [31:0] refMem [0:1023];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    mem_access_unit #(.SIZE(4096)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data)
    );

    always #5 clk = ~clk;

    // Cycle counter: value k holds between posedge k and posedge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read word memory with one cycle of read latency.
    always @(posedge clk) begin
        mem_read_data <= memArr[mem_read_addr[11:2]];
        if (mem_write_en) memArr[mem_write_addr[11:2]] <= mem_write_data;
    end

    // Scoreboard monitor: every response and write must match the queue head.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            compared++;
            if (respQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_resp cyc=%0d rdata=%08h err=%0b", cyc, resp_rdata, resp_err);
            end else begin
                resp_t e;
                e = respQ.pop_front();
                if (e.cyc !== cyc || resp_rdata !== e.rdata || resp_err !== e.err) begin
                    mismatched++;
                    $display("[TB] FAIL resp got cyc=%0d rdata=%08h err=%0b expected cyc=%0d rdata=%08h err=%0b",
                             cyc, resp_rdata, resp_err, e.cyc, e.rdata, e.err);
                end
            end
        end
        if (mem_write_en === 1'b1) begin
            compared++;
            if (writeQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_write cyc=%0d addr=%08h data=%08h", cyc, mem_write_addr, mem_write_data);
            end else begin
                write_t w;
                w = writeQ.pop_front();
                if (w.cyc !== cyc || mem_write_addr !== w.addr || mem_write_data !== w.data) begin
                    mismatched++;
                    $display("[TB] FAIL write got cyc=%0d addr=%08h data=%08h expected cyc=%0d addr=%08h data=%08h",
                             cyc, mem_write_addr, mem_write_data, w.cyc, w.addr, w.data);
                end
            end
        end
    end

    // Reference lane extraction: shift the lane down, then fill above it.
    function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        logic [31:0] v;
        sh = word >> (8 * lo);
        if (size == 2'b00) begin
            v = sh & 32'h0000_00FF;
            if (sgn && sh[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = sh & 32'h0000_FFFF;
            if (sgn && sh[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Drive one request once the unit is ready and queue what it should do.
    task automatic issue(input logic isStore, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        int          t;
        logic        err;
        logic [31:0] oldW;
        logic [31:0] newW;
        logic [31:0] mask;
        int          idx;
        req_valid = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ready_timeout got req_ready=%0b expected 1", req_ready);
        end
        req_is_store = isStore;
        req_size     = size;
        req_signed   = sgn;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        t   = cyc;
        idx = int'(addr[11:2]);
        err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'd4096);
        if (err) begin
            respQ.push_back('{t + 1, 32'h0, 1'b1});
        end else if (isStore) begin
            oldW = refMem[idx];
            if (size == 2'b10) begin
                newW = wdata;
                writeQ.push_back('{t, {addr[31:2], 2'b00}, newW});
                respQ.push_back('{t + 1, 32'h0, 1'b0});
            end else begin
                mask = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * addr[1:0]);
                newW = (oldW & ~mask) | ((wdata << (8 * addr[1:0])) & mask);
                writeQ.push_back('{t + 1, {addr[31:2], 2'b00}, newW});
                respQ.push_back('{t + 2, 32'h0, 1'b0});
            end
            refMem[idx] = newW;
        end else begin
            respQ.push_back('{t + 2, modelLoad(refMem[idx], addr[1:0], size, sgn), 1'b0});
        end
        @(posedge clk); #1;
    endtask

    // Let outstanding responses drain (bounded; leftovers are caught at the end).
    task automatic drain();
        int n;
        req_valid = 1'b0;
        n = 0;
        while ((respQ.size() != 0 || writeQ.size() != 0) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_size     = 2'b00;
        req_signed   = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (2) begin @(posedge clk); #1; end
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_size     = 2'b10;
        req_addr     = 32'h40;
        req_wdata    = 32'h1234_5678;
        #1;
        compared++;
        if (mem_write_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_write_en got %0b expected 0", mem_write_en);
        end
        @(posedge clk); #1;
        compared++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got valid=%0b err=%0b rdata=%08h expected 0/0/0",
                     resp_valid, resp_err, resp_rdata);
        end
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_ready got %0b expected 1", req_ready);
        end
        req_valid = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store_load();
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        drain();
    endtask

    task automatic test_sub_word_loads();
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        drain();
    endtask

    task automatic test_sub_word_store();
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
        compared++;
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL merge_ready got %0b expected 0", req_ready);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_1357);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        drain();
    endtask

    task automatic test_errors();
        issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFE_F00D);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h1003, 32'h55);
        drain();
    endtask

    task automatic test_reset_mid_merge();
        req_valid = 1'b0;
        @(posedge clk); #1;
        req_is_store = 1'b1;
        req_size     = 2'b00;
        req_signed   = 1'b0;
        req_addr     = 32'h21;
        req_wdata    = 32'h0000_0077;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        compared++;
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_merge_ready got %0b expected 0", req_ready);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (mem_write_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_merge_write got %0b expected 0", mem_write_en);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        compared++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL after_reset got ready=%0b resp_valid=%0b expected 1/0", req_ready, resp_valid);
        end
        repeat (2) begin @(posedge clk); #1; end
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        drain();
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h1111_1111);
        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h2222_2222);
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h3333_3333);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? (32'h1000 + $urandom_range(0, 15))
                                             : 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            memArr[i] = 32'h0;
            refMem[i] = 32'h0;
        end
        test_reset();
        test_word_store_load();
        test_sub_word_loads();
        test_sub_word_store();
        test_errors();
        test_reset_mid_merge();
        test_back_to_back();
        test_random();
        compared++;
        if (respQ.size() != 0 || writeQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL pending got resp=%0d write=%0d expected 0/0", respQ.size(), writeQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
